// File: rtl/debounce_fsm_if.sv
// ============================================================================
// Module      : debounce_fsm_if
// Description : Switch-side and debounced-side signals of the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_fsm_if;
    logic sw;        // raw, bouncing, asynchronous switch level
    logic db_level;  // debounced level
    logic db_tick;   // one-cycle pulse on each debounced 0->1 transition

    modport master (
        output sw,
        input  db_level,
        input  db_tick
    );

    modport slave (
        input  sw,
        output db_level,
        output db_tick
    );
endinterface

`default_nettype wire

// File: rtl/debounce_fsm.sv
// ============================================================================
// Module      : debounce_fsm
// Description : Switch debouncer; a new level must hold across three 2^N-cycle
//               sample ticks before it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_fsm #(
    parameter int N = 19
) (
    input  wire logic     clk,
    input  wire logic     reset,
    debounce_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        WAIT1_1 = 3'd1,
        WAIT1_2 = 3'd2,
        WAIT1_3 = 3'd3,
        ONE     = 3'd4,
        WAIT0_1 = 3'd5,
        WAIT0_2 = 3'd6,
        WAIT0_3 = 3'd7
    } state_t;

    logic         s1;
    logic         s2;
    logic         sw_s;
    logic [N-1:0] q;
    logic         m_tick;
    state_t       state;
    logic         level_reg;

    // Two-flop synchronizer: sw is asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.sw;
            s2 <= s1;
        end
    end

    assign sw_s = s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q + 1'b1;
        end
    end

    assign m_tick = &q;

    // level_reg is updated together with the state so it always equals the
    // Moore decode of the state register (1 in ONE and WAIT0_x).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ZERO;
            level_reg <= 1'b0;
        end else begin
            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1_1;
                    end
                end
                WAIT1_1: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (m_tick) begin
                        state <= WAIT1_2;
                    end
                end
                WAIT1_2: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (m_tick) begin
                        state <= WAIT1_3;
                    end
                end
                WAIT1_3: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (m_tick) begin
                        state     <= ONE;
                        level_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0_1;
                    end
                end
                WAIT0_1: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (m_tick) begin
                        state <= WAIT0_2;
                    end
                end
                WAIT0_2: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (m_tick) begin
                        state <= WAIT0_3;
                    end
                end
                WAIT0_3: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (m_tick) begin
                        state     <= ZERO;
                        level_reg <= 1'b0;
                    end
                end
                default: begin
                    state     <= ZERO;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_level = level_reg;
    // Mealy pulse: high during the cycle that commits WAIT1_3 -> ONE, so it
    // leads the db_level rise by one cycle. Bounce (sw_s=0) wins over m_tick.
    assign bus.db_tick  = (state == WAIT1_3) && sw_s && m_tick;

endmodule

`default_nettype wire

// File: tb/tb_debounce_fsm.sv
// ============================================================================
// Module      : tb_debounce_fsm
// Description : Directed and random stimulus against a level/tick-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_fsm;

    localparam int N = 3;
    localparam int P = 1 << N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    debounce_fsm_if bus ();

    debounce_fsm #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: synchronizer history, sample phase, accepted level, and how many
    // sample ticks a pending opposite level has survived.
    bit m_s1, m_s2, m_lvl, m_pend;
    int m_q, m_cnt;
    logic obs_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = 0; m_q = 0; m_cnt = 0;
    endtask

    function automatic bit exp_tick();
        return m_pend && !m_lvl && m_s2 && (m_q == P - 1) && (m_cnt == 2);
    endfunction

    task automatic model_advance(input bit v);
        bit tick;
        tick = (m_q == P - 1);
        if (!m_pend) begin
            if (m_s2 != m_lvl) begin
                m_pend = 1;
                m_cnt  = 0;
            end
        end else if (m_s2 == m_lvl) begin
            m_pend = 0;
        end else if (tick) begin
            m_cnt++;
            if (m_cnt == 3) begin
                m_lvl  = m_s2;
                m_pend = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = v;
        m_q  = (m_q + 1) % P;
    endtask

    // Entered and left at a falling clock edge.
    task automatic step(input bit v);
        bus.sw = v;
        #1;
        chk("db_level", {31'd0, bus.db_level}, {31'd0, m_lvl});
        chk("db_tick", {31'd0, bus.db_tick}, {31'd0, exp_tick()});
        obs_tick = bus.db_tick;
        model_advance(v);
        @(negedge clk);
    endtask

    task automatic settle(input bit v, output int n, output int ticks, output int tpos);
        n = 0; ticks = 0; tpos = -1;
        while (bus.db_level !== v && n < 40) begin
            step(v);
            n++;
            if (obs_tick === 1'b1) begin
                ticks++;
                tpos = n;
            end
        end
    endtask

    int n, ticks, tpos, k;

    initial begin
        bus.sw = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_level", {31'd0, bus.db_level}, 32'd0);
        chk("reset_tick", {31'd0, bus.db_tick}, 32'd0);
        chk("reset_q", {{(32-N){1'b0}}, dut.q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) step(0);

        // Clean press.
        settle(1, n, ticks, tpos);
        chk("clean_rise_in_window", {31'd0, (n >= 18 && n <= 27)}, 32'd1);
        chk("clean_tick_count", ticks, 32'd1);
        chk("clean_tick_before_rise", tpos, n);
        repeat (10) step(1);

        // Glitch-free release back to ZERO, then bounce on press.
        settle(0, n, ticks, tpos);
        chk("release_no_tick", ticks, 32'd0);
        repeat (5) step(0);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step(((i / 3) % 2) == 0);
            if (obs_tick === 1'b1) ticks++;
        end
        chk("bounce_no_tick", ticks, 32'd0);
        settle(1, n, ticks, tpos);
        chk("bounce_settle_tick_count", ticks, 32'd1);
        chk("bounce_level", {31'd0, bus.db_level}, 32'd1);
        repeat (5) step(1);

        // Release with a one-cycle high glitch while in WAIT0_x.
        ticks = 0;
        repeat (12) begin
            step(0);
            if (obs_tick === 1'b1) ticks++;
        end
        step(1);
        if (obs_tick === 1'b1) ticks++;
        chk("wait0_glitch_level_held", {31'd0, bus.db_level}, 32'd1);
        chk("wait0_glitch_no_tick", ticks, 32'd0);
        settle(0, n, ticks, tpos);
        chk("release_fall_in_window", {31'd0, (n >= 18 && n <= 27)}, 32'd1);
        chk("release_fall_no_tick", ticks, 32'd0);
        repeat (5) step(0);

        // Short glitch never qualifies.
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step(i < 10);
            if (obs_tick === 1'b1) ticks++;
        end
        chk("short_glitch_no_tick", ticks, 32'd0);
        chk("short_glitch_level", {31'd0, bus.db_level}, 32'd0);

        // Asynchronous reset while in WAIT1_2, away from q wrap.
        k = 0;
        while (!(m_pend && m_cnt == 1 && m_q == 3) && k < 60) begin
            step(1);
            k++;
        end
        if (!(m_pend && m_cnt == 1 && m_q == 3)) begin
            checks++;
            errors++;
            $error("FAIL wait1_2_reach_timeout observed=%0d expected=%0d", k, 60);
        end
        reset = 1'b1;
        #1;
        chk("async_rst_q", {{(32-N){1'b0}}, dut.q}, 32'd0);
        chk("async_rst_level", {31'd0, bus.db_level}, 32'd0);
        chk("async_rst_tick", {31'd0, bus.db_tick}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        settle(1, n, ticks, tpos);
        chk("post_rst_rise_in_window", {31'd0, (n >= 18 && n <= 27)}, 32'd1);
        chk("post_rst_tick_count", ticks, 32'd1);
        repeat (3) step(1);
        settle(0, n, ticks, tpos);
        repeat (5) step(0);

        // Tie-break: sw_s drops exactly when m_tick fires in WAIT1_3.
        ticks = 0;
        k = 0;
        while (!(m_pend && m_cnt == 2 && m_q == P - 3) && k < 60) begin
            step(1);
            k++;
            if (obs_tick === 1'b1) ticks++;
        end
        repeat (30) begin
            step(0);
            if (obs_tick === 1'b1) ticks++;
        end
        chk("tiebreak_no_tick", ticks, 32'd0);
        chk("tiebreak_level", {31'd0, bus.db_level}, 32'd0);

        // Random segments of random level and length.
        for (int seg = 0; seg < 40; seg++) begin
            bit v;
            int len;
            v   = 1'($urandom % 2);
            len = $urandom_range(1, 30);
            repeat (len) step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
